// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: baud divider table,
// parity encoding and transmitter FSM states.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_e;

    localparam int OVERSAMPLE = 16;
    // Wide enough for the slowest bit: 16 * 10417 - 1.
    localparam int BAUD_CNT_W = 18;

    function automatic int baud_div(input logic [2:0] code);
        case (code)
            3'd0:    return 10417;
            3'd1:    return 2604;
            3'd2:    return 651;
            3'd3:    return 326;
            3'd4:    return 163;
            3'd5:    return 81;
            3'd6:    return 54;
            default: return 27;
        endcase
    endfunction

    function automatic logic [BAUD_CNT_W-1:0] bit_last(input logic [2:0] code);
        return BAUD_CNT_W'(OVERSAMPLE * baud_div(code) - 1);
    endfunction

    function automatic logic parity_bit(input logic [8:0] d, input parity_e mode);
        case (mode)
            PAR_EVEN: return ^d;
            PAR_ODD:  return ~^d;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_transmitter_if.sv
// Host-side bundle of the UART transmitter: write port, line configuration,
// serial output and status flags.
interface uart_fifo_transmitter_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] Tx_DATA;
    logic              Tx_WR;
    logic              Tx_EN;
    logic [2:0]        baud_select;
    logic [1:0]        parity_mode;
    logic              stop2;
    logic              TxD;
    logic              Tx_BUSY;
    logic              Tx_FULL;
    logic              Tx_EMPTY;
    logic              Tx_OVR;

    modport master (
        output Tx_DATA, Tx_WR, Tx_EN, baud_select, parity_mode, stop2,
        input  TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_OVR
    );

    modport slave (
        input  Tx_DATA, Tx_WR, Tx_EN, baud_select, parity_mode, stop2,
        output TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_OVR
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO with extra-bit pointers; a push into a full FIFO succeeds
// only when a pop happens in the same cycle, otherwise it raises ovr.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              ovr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              do_rd, do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovr    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            ovr <= wr && !do_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_fifo_transmitter.sv
// FIFO-fed UART transmitter: frames start/data/parity/stop with per-frame
// configuration latched at the pop; dropping Tx_EN aborts the current frame.
module uart_fifo_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_fifo_transmitter_if.slave  bus
);
    localparam int IDX_W = $clog2(DATA_W);

    tx_state_e               state, state_nxt;
    logic                    pop, fifo_full, fifo_empty, fifo_ovr;
    logic [DATA_W-1:0]       fifo_rdata, shreg;
    logic [BAUD_CNT_W-1:0]   cnt, bit_last_q;
    logic [IDX_W-1:0]        bit_idx;
    logic                    stop_idx, stop2_q, par_q, par_en_q;
    logic                    bit_end, last_data, stop_done, txd;

    uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.Tx_WR),
        .wdata (bus.Tx_DATA),
        .rd    (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovr   (fifo_ovr)
    );

    assign bit_end   = (cnt == bit_last_q);
    assign last_data = (bit_idx == IDX_W'(DATA_W - 1));
    assign stop_done = (stop_idx == stop2_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: if (bus.Tx_EN && !fifo_empty) begin
                pop       = 1'b1;
                state_nxt = ST_START;
            end
            ST_START:  if (bit_end) state_nxt = ST_DATA;
            ST_DATA:   if (bit_end && last_data) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
            ST_STOP: if (bit_end && stop_done) begin
                // Chain straight into the next start bit when work is queued.
                if (bus.Tx_EN && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE && !bus.Tx_EN) begin
            pop       = 1'b0;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            bit_last_q <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
        end else if (pop) begin
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= fifo_rdata;
            bit_last_q <= bit_last(bus.baud_select);
            par_en_q   <= (parity_e'(bus.parity_mode) != PAR_NONE);
            par_q      <= parity_bit(9'(fifo_rdata), parity_e'(bus.parity_mode));
            stop2_q    <= bus.stop2;
        end else if (state != ST_IDLE) begin
            if (bit_end) begin
                cnt <= '0;
                if (state == ST_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 1'b1;
                end
                if (state == ST_STOP) stop_idx <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        txd = 1'b1;
        case (state)
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = shreg[0];
            ST_PARITY: txd = par_q;
            default:   txd = 1'b1;
        endcase
    end

    assign bus.TxD      = txd;
    assign bus.Tx_BUSY  = (state != ST_IDLE);
    assign bus.Tx_FULL  = fifo_full;
    assign bus.Tx_EMPTY = fifo_empty;
    assign bus.Tx_OVR   = fifo_ovr;
endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Bench for uart_fifo_transmitter: table vectors, FIFO/abort/reset sequences and
// randomized frames checked cycle-by-cycle against a frame model.
module tb_uart_fifo_transmitter;
    logic clk = 1'b0;
    logic reset, reset7;
    always #5 clk = ~clk;

    uart_fifo_transmitter_if #(.DATA_W(8)) bus ();
    uart_fifo_transmitter_if #(.DATA_W(7)) bus7 ();

    uart_fifo_transmitter #(.DATA_W(8), .FIFO_DEPTH(4)) dut  (.clk(clk), .reset(reset),  .bus(bus));
    uart_fifo_transmitter #(.DATA_W(7), .FIFO_DEPTH(4)) dut7 (.clk(clk), .reset(reset7), .bus(bus7));

    int total = 0;
    int bad   = 0;
    int div_ref [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

    typedef struct {
        logic [7:0] data;
        logic [2:0] code;
        logic [1:0] pm;
        logic       s2;
        logic       exp_par;
        int         exp_len;
        string      tag;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    function automatic logic txd_of(input int sel);
        return (sel == 1) ? bus7.TxD : bus.TxD;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 1) ? bus7.Tx_BUSY : bus.Tx_BUSY;
    endfunction

    function automatic logic ref_par(input logic [7:0] d, input logic [1:0] pm);
        int ones = $countones(d);
        case (pm)
            2'b01:   return (ones % 2) == 1;
            2'b10:   return (ones % 2) == 0;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        bus.Tx_DATA = d;
        bus.Tx_WR   = 1'b1;
        @(negedge clk);
        bus.Tx_WR   = 1'b0;
    endtask

    // Waits for the start bit, then compares every cycle of the frame with the model.
    task automatic check_frame(input int sel, input logic [8:0] data, input int dw,
                               input logic [2:0] code, input logic [1:0] pm, input logic s2,
                               input logic par, input int exp_len, input int max_wait,
                               input string tag);
        logic exp_bits[$];
        int   period, w, busy_cnt, errs;
        logic found;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) exp_bits.push_back(data[i]);
        if (pm != 2'b00) exp_bits.push_back(par);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
        period = 16 * div_ref[code];
        found  = 1'b0;
        w      = 0;
        while (!found && w < max_wait) begin
            @(negedge clk);
            w++;
            if (txd_of(sel) == 1'b0) found = 1'b1;
        end
        chk({tag, " start"}, int'(found), 1);
        if (!found) return;
        busy_cnt = 0;
        for (int b = 0; b < exp_bits.size(); b++) begin
            errs = 0;
            for (int c = 0; c < period; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (txd_of(sel) != exp_bits[b]) errs++;
                if (busy_of(sel)) busy_cnt++;
            end
            chk($sformatf("%s bit%0d bad_cycles", tag, b), errs, 0);
        end
        chk({tag, " busy_len"}, busy_cnt, exp_len);
    endtask

    task automatic set_cfg(input logic [2:0] code, input logic [1:0] pm, input logic s2);
        bus.baud_select = code;
        bus.parity_mode = pm;
        bus.stop2       = s2;
    endtask

    task automatic run_main();
        vec_t       vecs [4];
        logic [7:0] w [6];
        int         cyc, errs;
        logic       found;

        vecs[0] = '{8'h9A, 3'd7, 2'b00, 1'b0, 1'b0, 4320, "8N1"};
        vecs[1] = '{8'h9A, 3'd7, 2'b01, 1'b1, 1'b0, 5184, "8E2"};
        vecs[2] = '{8'h9A, 3'd7, 2'b10, 1'b1, 1'b1, 5184, "8O2"};
        vecs[3] = '{8'h9A, 3'd7, 2'b11, 1'b0, 1'b1, 4752, "8M1"};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_cfg(vecs[i].code, vecs[i].pm, vecs[i].s2);
            bus.Tx_EN = 1'b1;
            push(vecs[i].data);
            check_frame(0, {1'b0, vecs[i].data}, 8, vecs[i].code, vecs[i].pm, vecs[i].s2,
                        vecs[i].exp_par, vecs[i].exp_len, 4, vecs[i].tag);
            @(negedge clk);
            chk({vecs[i].tag, " idle_busy"}, int'(bus.Tx_BUSY), 0);
            chk({vecs[i].tag, " idle_txd"}, int'(bus.TxD), 1);
        end

        // Fill to overflow with the transmitter disabled.
        for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
        @(negedge clk);
        bus.Tx_EN = 1'b0;
        set_cfg(3'd7, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.Tx_DATA = w[i];
            bus.Tx_WR   = 1'b1;
            @(negedge clk);
            if (i == 3) chk("full_after_4", int'(bus.Tx_FULL), 1);
            if (i == 4) chk("ovr_on_5th", int'(bus.Tx_OVR), 1);
        end
        bus.Tx_WR = 1'b0;
        @(negedge clk);
        chk("ovr_one_cycle", int'(bus.Tx_OVR), 0);
        chk("still_full", int'(bus.Tx_FULL), 1);
        bus.Tx_EN   = 1'b1;
        bus.Tx_DATA = w[5];
        bus.Tx_WR   = 1'b1;
        fork
            check_frame(0, {1'b0, w[0]}, 8, 3'd7, 2'b00, 1'b0, 1'b0, 4320, 2, "fifo0");
            begin
                @(negedge clk);
                bus.Tx_WR = 1'b0;
                chk("push_pop_full_ovr", int'(bus.Tx_OVR), 0);
                chk("push_pop_full_full", int'(bus.Tx_FULL), 1);
            end
        join
        check_frame(0, {1'b0, w[1]}, 8, 3'd7, 2'b00, 1'b0, 1'b0, 4320, 1, "fifo1");
        check_frame(0, {1'b0, w[2]}, 8, 3'd7, 2'b00, 1'b0, 1'b0, 4320, 1, "fifo2");
        check_frame(0, {1'b0, w[3]}, 8, 3'd7, 2'b00, 1'b0, 1'b0, 4320, 1, "fifo3");
        check_frame(0, {1'b0, w[5]}, 8, 3'd7, 2'b00, 1'b0, 1'b0, 4320, 1, "fifo4");
        @(negedge clk);
        chk("fifo_drain_busy", int'(bus.Tx_BUSY), 0);
        chk("fifo_drain_empty", int'(bus.Tx_EMPTY), 1);

        // Abort at cycle 1000 of a frame; queued words must survive.
        bus.Tx_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i] = 8'($urandom);
            push(w[i]);
        end
        @(negedge clk);
        bus.Tx_EN = 1'b1;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.TxD == 1'b0) found = 1'b1;
        end
        chk("abort start", int'(found), 1);
        repeat (999) @(negedge clk);
        bus.Tx_EN = 1'b0;
        @(negedge clk);
        chk("abort_txd", int'(bus.TxD), 1);
        chk("abort_busy", int'(bus.Tx_BUSY), 0);
        chk("abort_kept_fifo", int'(bus.Tx_EMPTY), 0);
        bus.Tx_EN = 1'b1;
        check_frame(0, {1'b0, w[1]}, 8, 3'd7, 2'b00, 1'b0, 1'b0, 4320, 5, "after_abort1");
        check_frame(0, {1'b0, w[2]}, 8, 3'd7, 2'b00, 1'b0, 1'b0, 4320, 1, "after_abort2");
        @(negedge clk);
        chk("after_abort_idle", int'(bus.Tx_BUSY), 0);

        // Reset mid-frame with two words still queued.
        bus.Tx_EN = 1'b0;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        @(negedge clk);
        bus.Tx_EN = 1'b1;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.TxD == 1'b0) found = 1'b1;
        end
        chk("rst_frame start", int'(found), 1);
        repeat (100) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_txd", int'(bus.TxD), 1);
        chk("midrst_busy", int'(bus.Tx_BUSY), 0);
        chk("midrst_empty", int'(bus.Tx_EMPTY), 1);
        chk("midrst_full", int'(bus.Tx_FULL), 0);
        @(negedge clk);
        reset = 1'b1;
        errs = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.TxD != 1'b1 || bus.Tx_BUSY) errs++;
        end
        chk("post_rst_silent", errs, 0);
        w[0] = 8'($urandom);
        push(w[0]);
        check_frame(0, {1'b0, w[0]}, 8, 3'd7, 2'b00, 1'b0, 1'b0, 4320, 4, "post_rst");

        // Random configurations; changes made mid-frame apply to the next frame only.
        for (int p = 0; p < 2; p++) begin
            logic [7:0] wa, wb;
            logic [1:0] pa, pb;
            logic       sa, sb;
            int         lena, lenb;
            wa = 8'($urandom);
            wb = 8'($urandom);
            pa = 2'($urandom_range(0, 3));
            pb = 2'($urandom_range(0, 3));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            lena = (10 + (pa != 2'b00 ? 1 : 0) + (sa ? 1 : 0)) * 16 * div_ref[7];
            lenb = (10 + (pb != 2'b00 ? 1 : 0) + (sb ? 1 : 0)) * 16 * div_ref[7];
            @(negedge clk);
            bus.Tx_EN = 1'b0;
            set_cfg(3'd7, pa, sa);
            push(wa);
            push(wb);
            @(negedge clk);
            bus.Tx_EN = 1'b1;
            fork
                check_frame(0, {1'b0, wa}, 8, 3'd7, pa, sa, ref_par(wa, pa), lena, 3,
                            $sformatf("rnd%0dA", p));
                begin
                    repeat (3) @(negedge clk);
                    bus.baud_select = 3'($urandom_range(0, 6));
                    bus.parity_mode = pb;
                    bus.stop2       = sb;
                    repeat (100) @(negedge clk);
                    bus.baud_select = 3'd7;
                end
            join
            check_frame(0, {1'b0, wb}, 8, 3'd7, pb, sb, ref_par(wb, pb), lenb, 1,
                        $sformatf("rnd%0dB", p));
            @(negedge clk);
            chk($sformatf("rnd%0d idle", p), int'(bus.Tx_BUSY), 0);
        end
    endtask

    task automatic run_dw7();
        @(negedge clk);
        bus7.baud_select = 3'd3;
        bus7.parity_mode = 2'b00;
        bus7.stop2       = 1'b0;
        bus7.Tx_EN       = 1'b1;
        bus7.Tx_DATA     = 7'h55;
        bus7.Tx_WR       = 1'b1;
        @(negedge clk);
        bus7.Tx_WR = 1'b0;
        check_frame(1, 9'h055, 7, 3'd3, 2'b00, 1'b0, 1'b0, 9 * 5216, 4, "dw7");
        @(negedge clk);
        chk("dw7 idle", int'(bus7.Tx_BUSY), 0);
    endtask

    initial begin
        reset  = 1'b0;
        reset7 = 1'b0;
        bus.Tx_DATA = '0;  bus.Tx_WR = 1'b0;  bus.Tx_EN = 1'b0;
        bus.baud_select = 3'd7;  bus.parity_mode = 2'b00;  bus.stop2 = 1'b0;
        bus7.Tx_DATA = '0; bus7.Tx_WR = 1'b0; bus7.Tx_EN = 1'b0;
        bus7.baud_select = 3'd3; bus7.parity_mode = 2'b00; bus7.stop2 = 1'b0;
        #1;
        chk("rst_txd", int'(bus.TxD), 1);
        chk("rst_busy", int'(bus.Tx_BUSY), 0);
        chk("rst_empty", int'(bus.Tx_EMPTY), 1);
        chk("rst_full", int'(bus.Tx_FULL), 0);
        chk("rst_ovr", int'(bus.Tx_OVR), 0);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        reset7 = 1'b1;
        fork
            run_main();
            run_dw7();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: got no completion, wanted finish before time limit");
        $fatal(1, "time limit reached");
    end
endmodule

// File: doc/uart_fifo_transmitter.md
UART_FIFO_TRANSMITTER -- requirements
Module: uart_fifo_transmitter

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, 2..16.
REQ-003 Port clk  input  1: single clock, 50 MHz nominal; all state on rising edge.
REQ-004 Port reset  input  1: reset is asynchronous and active-low (asserted at 0).
REQ-005 Port Tx_DATA  input  DATA_W: word to enqueue.
REQ-006 Port Tx_WR  input  1: enqueue strobe, one word per cycle while high.
REQ-007 Port Tx_EN  input  1: transmitter enable.
REQ-008 Port baud_select  input  3: rate code 000..111 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
REQ-009 Port parity_mode  input  2: 00 none, 01 even, 10 odd, 11 mark (always 1).
REQ-010 Port stop2  input  1: 0 = one stop bit, 1 = two stop bits.
REQ-011 Port TxD  output  1: serial line, idle high.
REQ-012 Port Tx_BUSY  output  1: frame in progress.
REQ-013 Port Tx_FULL / Tx_EMPTY  output  1 each: FIFO status.
REQ-014 Port Tx_OVR  output  1: one-cycle pulse, write dropped.

Function
REQ-015 Bit period SHALL be 16 x DIV[baud_select] clk cycles; DIV = 10417, 2604, 651, 326, 163, 81, 54, 27.
REQ-016 Tx_WR high and FIFO not full SHALL push Tx_DATA; Tx_WR high while full SHALL drop the word and pulse Tx_OVR next cycle.
REQ-017 Push and pop in the same cycle while full SHALL both succeed; push to an empty FIFO SHALL make data poppable the following cycle.
REQ-018 FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when Tx_EN=1 and FIFO not empty, popping one word.
REQ-019 TxD SHALL drive 0 on the cycle after the pop; the baud counter SHALL restart at 0 on that cycle.
REQ-020 DATA SHALL shift DATA_W bits LSB first; PARITY skipped when parity_mode=00; STOP lasts 1 or 2 bit periods.
REQ-021 baud_select, parity_mode, stop2 SHALL be latched at the pop; changes mid-frame take effect on the next frame only.
REQ-022 STOP->START directly (no idle bit) when Tx_EN=1 and FIFO not empty at end of stop; else ->IDLE.
REQ-023 Tx_EN deasserted mid-frame SHALL abort: ->IDLE, TxD=1 next cycle, popped word lost, FIFO retained.
REQ-024 Tx_BUSY SHALL be 1 in every state except IDLE.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH with one extra bit for full/empty discrimination.

Reset
REQ-026 Asserted reset SHALL force, without clock: TxD=1, Tx_BUSY=0, Tx_EMPTY=1, Tx_FULL=0, Tx_OVR=0, state IDLE, pointers and counters 0.
REQ-027 Reset mid-frame SHALL discard the frame and all FIFO contents; first push permitted on the first clk edge after release.

Structure
REQ-028 Package uart_pkg SHALL hold the DIV table, the parity_mode encoding and the FSM state enum.
REQ-029 FIFO SHALL be sub-module uart_tx_fifo (params DATA_W, FIFO_DEPTH).

Verification
REQ-030 8N1, code 111, push 0x9A -> TxD 0,0,1,0,1,1,0,0,1,1, each 432 cycles; Tx_BUSY high 4320 cycles.
REQ-031 Even parity, 0x9A -> parity bit 0; odd -> 1; mark -> 1; stop2=1 -> frame 11 bits + extra stop = 5184 cycles.
REQ-032 Push 5 words with FIFO_DEPTH=4 while Tx_EN=0 -> Tx_FULL after 4th, Tx_OVR pulse on 5th, 4 frames sent back-to-back after Tx_EN=1.
REQ-033 Tx_EN low at cycle 1000 of a frame -> TxD=1 next cycle, Tx_BUSY=0, remaining FIFO words still transmitted later.
REQ-034 Reset low mid-frame with 2 words queued -> TxD=1, Tx_EMPTY=1 immediately; no frame after release until a new push.
REQ-035 DATA_W=7, code 011, 0x55 -> 7 data bits 1,0,1,0,1,0,1 each 5216 cycles.
